// File: rtl/truth_table_sweeper.sv
// Exhaustive truth-table checker for a 5-input combinational block: walks every
// {A,B,C,D,E} vector, waits SETTLE cycles, samples Y and tallies mismatches.
module truth_table_sweeper #(
    parameter int          SETTLE      = 4,
    parameter logic [31:0] EXPECT_MASK = 32'h30F0_30F0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic [4:0] vec_o,
    input  logic       y_i,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [5:0] err_count,
    output logic [4:0] first_fail_vec,
    output logic       first_fail_valid,
    output logic [1:0] state_dbg
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HOLD = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);

    logic [1:0] state;
    logic [7:0] cnt;
    logic       mismatch;
    logic [5:0] err_next;

    // Handshake: start is a level sampled only in IDLE (no ready); busy covers
    // the whole sweep and done is a single-cycle completion pulse.
    always_comb begin
        mismatch = 1'b0;
        err_next = err_count;
        mismatch = (y_i != EXPECT_MASK[vec_o]);
        err_next = err_count + 6'(mismatch);
    end

    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            cnt              <= 8'd0;
            vec_o            <= 5'd0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= 6'd0;
            first_fail_vec   <= 5'd0;
            first_fail_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state            <= HOLD;
                        vec_o            <= 5'd0;
                        cnt              <= 8'd0;
                        busy             <= 1'b1;
                        err_count        <= 6'd0;
                        pass             <= 1'b0;
                        first_fail_valid <= 1'b0;
                        first_fail_vec   <= 5'd0;
                    end
                end
                HOLD: begin
                    if (cnt == SETTLE_LAST) begin
                        if (mismatch) begin
                            err_count <= err_next;
                            if (!first_fail_valid) begin
                                first_fail_vec   <= vec_o;
                                first_fail_valid <= 1'b1;
                            end
                        end
                        cnt <= 8'd0;
                        if (vec_o == 5'd31) begin
                            // pass must include the last vector's own result
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            vec_o <= 5'd0;
                            pass  <= (err_next == 6'd0);
                        end else begin
                            vec_o <= vec_o + 5'd1;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: two instances (SETTLE=4 and SETTLE=1) driven
// by behavioural gate models, checked cycle by cycle against a reference.
module tb_truth_table_sweeper;

    logic       clk;
    logic       rst_n;
    logic       start_s     [2];
    logic [4:0] vec_s       [2];
    logic       y_s         [2];
    logic       busy_s      [2];
    logic       done_s      [2];
    logic       pass_s      [2];
    logic [5:0] err_s       [2];
    logic [4:0] ffvec_s     [2];
    logic       ffv_s       [2];
    logic [1:0] state_s     [2];

    int          mode      [2];
    logic [31:0] rnd_mask  [2];
    int          done_cnt  [2];
    int          total = 0;
    int          bad   = 0;

    truth_table_sweeper #(.SETTLE(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start_s[0]), .vec_o(vec_s[0]),
        .y_i(y_s[0]), .busy(busy_s[0]), .done(done_s[0]), .pass(pass_s[0]),
        .err_count(err_s[0]), .first_fail_vec(ffvec_s[0]),
        .first_fail_valid(ffv_s[0]), .state_dbg(state_s[0])
    );

    truth_table_sweeper #(.SETTLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_s[1]), .vec_o(vec_s[1]),
        .y_i(y_s[1]), .busy(busy_s[1]), .done(done_s[1]), .pass(pass_s[1]),
        .err_count(err_s[1]), .first_fail_vec(ffvec_s[1]),
        .first_fail_valid(ffv_s[1]), .state_dbg(state_s[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Intended gate function: Y = C & (~B | ~D), bits A,B,C,D,E = v[4..0]
    function automatic logic ref_y(input logic [4:0] v);
        return v[2] & (~v[3] | ~v[1]);
    endfunction

    // 0 correct, 1 stuck-at-0, 2 inverted, 3 random per-vector response
    function automatic logic block_y(input int md, input logic [31:0] rm, input logic [4:0] v);
        case (md)
            0:       return ref_y(v);
            1:       return 1'b0;
            2:       return ~ref_y(v);
            default: return rm[v];
        endcase
    endfunction

    always_comb begin
        y_s[0] = block_y(mode[0], rnd_mask[0], vec_s[0]);
        y_s[1] = block_y(mode[1], rnd_mask[1], vec_s[1]);
    end

    always @(posedge clk) begin
        if (done_s[0]) done_cnt[0] <= done_cnt[0] + 1;
        if (done_s[1]) done_cnt[1] <= done_cnt[1] + 1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input int w, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, w, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag, input int w);
        chk({tag, "_vec"}, w, 32'(vec_s[w]), 0);
        chk({tag, "_busy"}, w, 32'(busy_s[w]), 0);
        chk({tag, "_done"}, w, 32'(done_s[w]), 0);
        chk({tag, "_pass"}, w, 32'(pass_s[w]), 0);
        chk({tag, "_err"}, w, 32'(err_s[w]), 0);
        chk({tag, "_ffvec"}, w, 32'(ffvec_s[w]), 0);
        chk({tag, "_ffv"}, w, 32'(ffv_s[w]), 0);
    endtask

    // Called at a negedge; leaves at the negedge after done has dropped.
    task automatic sweep(input int w, input int md, input bit start_at5, input bit start_in_done);
        int s;
        int exp_err;
        int exp_first;
        int dc0;
        s = (w == 0) ? 4 : 1;
        mode[w] = md;
        if (md == 3) rnd_mask[w] = $urandom;
        exp_err = 0;
        exp_first = -1;
        for (int v = 0; v < 32; v++) begin
            if (block_y(md, rnd_mask[w], 5'(v)) != ref_y(5'(v))) begin
                exp_err++;
                if (exp_first < 0) exp_first = v;
            end
        end
        dc0 = done_cnt[w];
        start_s[w] = 1'b1;
        @(negedge clk);
        start_s[w] = 1'b0;
        for (int j = 0; j < 32 * s; j++) begin
            chk("hold_vec", w, 32'(vec_s[w]), 32'(j / s));
            chk("hold_busy", w, 32'(busy_s[w]), 1);
            chk("hold_done", w, 32'(done_s[w]), 0);
            start_s[w] = (start_at5 && j == 5 * s) ? 1'b1 : 1'b0;
            @(negedge clk);
        end
        start_s[w] = 1'b0;
        chk("end_done", w, 32'(done_s[w]), 1);
        chk("end_busy", w, 32'(busy_s[w]), 0);
        chk("end_vec", w, 32'(vec_s[w]), 0);
        chk("end_pass", w, 32'(pass_s[w]), (exp_err == 0) ? 1 : 0);
        chk("end_err", w, 32'(err_s[w]), 32'(exp_err));
        chk("end_ffv", w, 32'(ffv_s[w]), (exp_first >= 0) ? 1 : 0);
        chk("end_ffvec", w, 32'(ffvec_s[w]), (exp_first >= 0) ? 32'(exp_first) : 0);
        if (start_in_done) start_s[w] = 1'b1;
        @(negedge clk);
        start_s[w] = 1'b0;
        chk("post_done", w, 32'(done_s[w]), 0);
        chk("post_busy", w, 32'(busy_s[w]), 0);
        chk("post_pass", w, 32'(pass_s[w]), (exp_err == 0) ? 1 : 0);
        chk("done_pulses", w, 32'(done_cnt[w] - dc0), 1);
    endtask

    initial begin
        int found;
        int dc_before;
        rst_n = 1'b0;
        start_s[0] = 1'b0;
        start_s[1] = 1'b0;
        mode[0] = 0;
        mode[1] = 0;
        rnd_mask[0] = 32'd0;
        rnd_mask[1] = 32'd0;
        done_cnt[0] = 0;
        done_cnt[1] = 0;
        @(negedge clk);
        @(negedge clk);
        chk_reset_vals("rst", 0);
        chk_reset_vals("rst", 1);
        rst_n = 1'b1;
        @(negedge clk);

        sweep(0, 0, 1'b0, 1'b0);
        sweep(0, 1, 1'b0, 1'b0);
        sweep(0, 2, 1'b0, 1'b0);
        sweep(0, 0, 1'b1, 1'b1);
        @(negedge clk);
        chk("idle_after_ignored_start", 0, 32'(busy_s[0]), 0);

        // Abandon a stuck-at-0 sweep at vector 10 via asynchronous reset
        mode[0] = 1;
        dc_before = done_cnt[0];
        start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (vec_s[0] == 5'd10) found = 1;
            else @(negedge clk);
        end
        chk("reach_vec10", 0, 32'(found), 1);
        chk("mid_err_nonzero", 0, 32'(err_s[0] != 6'd0), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midrst", 0);
        @(negedge clk);
        chk("midrst_no_done", 0, 32'(done_cnt[0] - dc_before), 0);
        rst_n = 1'b1;
        @(negedge clk);
        sweep(0, 1, 1'b0, 1'b0);

        sweep(1, 0, 1'b0, 1'b0);
        sweep(1, 0, 1'b0, 1'b0);
        sweep(1, 2, 1'b1, 1'b1);
        for (int r = 0; r < 4; r++) sweep(1, 3, 1'b0, 1'b0);
        sweep(0, 3, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
